controller_poll_sequencer: RTL

//  Sequences the serial read of both NES-style game controllers. It runs once per

---
 rtl/controller_pkg.sv | 38 +++
 rtl/controller_poll_sequencer_if.sv | 52 +++++
 rtl/controller_phase_timer.sv | 38 +++
 rtl/controller_poll_sequencer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/controller_pkg.sv
// Shared types and constants for the controller poll sequencer.
//   poll_state_t      : sequencer FSM states
//   *_DEFAULT         : default timing/width parameters
//   BTN_*             : bit positions of each button in a committed button byte
//   phase_width()     : width of the phase down-counter for given durations
package controller_pkg;

    localparam int unsigned NUM_BITS_DEFAULT     = 8;
    localparam int unsigned LATCH_CYCLES_DEFAULT = 2;
    localparam int unsigned CLK_DIV_DEFAULT      = 2;

    // First bit shifted out of the controller is A, so it lands in the MSB.
    localparam int unsigned BTN_A      = 7;
    localparam int unsigned BTN_B      = 6;
    localparam int unsigned BTN_SELECT = 5;
    localparam int unsigned BTN_START  = 4;
    localparam int unsigned BTN_UP     = 3;
    localparam int unsigned BTN_DOWN   = 2;
    localparam int unsigned BTN_LEFT   = 1;
    localparam int unsigned BTN_RIGHT  = 0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LATCH  = 3'd1,
        LOW    = 3'd2,
        HIGH   = 3'd3,
        COMMIT = 3'd4
    } poll_state_t;

    // Counter holds duration-1, so clog2 of the longest duration suffices (min 1 bit).
    function automatic int unsigned phase_width(input int unsigned latch_cycles,
                                                input int unsigned clk_div);
        int unsigned longest;
        longest = (clk_div > latch_cycles) ? clk_div : latch_cycles;
        return (longest > 1) ? $clog2(longest) : 1;
    endfunction

endpackage

// File: rtl/controller_poll_sequencer_if.sv
// Host/controller-side signal bundle of the poll sequencer.
//   enable, start              : poll request from the host
//   ctrl_1/2_data_in_B         : serial data from the controllers (active-low)
//   ctrl_latch, ctrl_clk       : shared latch strobe and shift clock to the controllers
//   buttons_1/2                : committed button bytes (active-high)
//   busy, done                 : poll in progress / new buttons visible this cycle
// slave  : sequencer side
// master : host + controller side
interface controller_poll_sequencer_if
    import controller_pkg::*;
#(
    parameter int unsigned NUM_BITS = NUM_BITS_DEFAULT
);

    logic                enable;
    logic                start;
    logic                ctrl_1_data_in_B;
    logic                ctrl_2_data_in_B;
    logic                ctrl_latch;
    logic                ctrl_clk;
    logic [NUM_BITS-1:0] buttons_1;
    logic [NUM_BITS-1:0] buttons_2;
    logic                busy;
    logic                done;

    modport slave (
        input  enable,
        input  start,
        input  ctrl_1_data_in_B,
        input  ctrl_2_data_in_B,
        output ctrl_latch,
        output ctrl_clk,
        output buttons_1,
        output buttons_2,
        output busy,
        output done
    );

    modport master (
        output enable,
        output start,
        output ctrl_1_data_in_B,
        output ctrl_2_data_in_B,
        input  ctrl_latch,
        input  ctrl_clk,
        input  buttons_1,
        input  buttons_2,
        input  busy,
        input  done
    );

endinterface

// File: rtl/controller_phase_timer.sv
// Loadable down-counter timing the LATCH/LOW/HIGH phases.
//   clk_1, rst_B : clock, async active-low reset
//   load         : (re)start the timer with load_val (= duration - 1)
//   load_val     : cycles remaining after the load cycle
//   expire_c     : high for exactly one cycle, the last cycle of the phase
module controller_phase_timer #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_1,
    input  logic             rst_B,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expire_c
);

    logic [WIDTH-1:0] count;
    logic             armed;

    // Counts down to zero and disarms, so expire fires once per load.
    always_ff @(posedge clk_1 or negedge rst_B) begin
        if (!rst_B) begin
            count <= '0;
            armed <= 1'b0;
        end else if (load) begin
            count <= load_val;
            armed <= 1'b1;
        end else if (armed) begin
            if (count == '0) begin
                armed <= 1'b0;
            end else begin
                count <= count - WIDTH'(1);
            end
        end
    end

    assign expire_c = armed && (count == '0);

endmodule

// File: rtl/controller_poll_sequencer.sv
// Serial poll of two NES-style controllers with atomic commit of both button bytes.
//   clk_1  : system clock (CPU domain)
//   rst_B  : async active-low reset
//   bus    : slave side of controller_poll_sequencer_if
//            (enable/start in, ctrl_latch/ctrl_clk out, serial data in,
//             buttons_1/2, busy, done out)
// Timing: start seen at cycle 0 -> latch cycles 1..LATCH_CYCLES, NUM_BITS
// low/high clock pairs of CLK_DIV cycles each, one COMMIT cycle, done visible
// at cycle LATCH_CYCLES + NUM_BITS*2*CLK_DIV + 2.
module controller_poll_sequencer
    import controller_pkg::*;
#(
    parameter int unsigned NUM_BITS     = NUM_BITS_DEFAULT,
    parameter int unsigned LATCH_CYCLES = LATCH_CYCLES_DEFAULT,
    parameter int unsigned CLK_DIV      = CLK_DIV_DEFAULT
) (
    input  logic                        clk_1,
    input  logic                        rst_B,
    controller_poll_sequencer_if.slave  bus
);

    localparam int unsigned CW = $clog2(NUM_BITS + 1);
    localparam int unsigned PW = phase_width(LATCH_CYCLES, CLK_DIV);

    poll_state_t         state;
    poll_state_t         state_d;
    logic [CW-1:0]       bit_cnt;
    logic [CW-1:0]       bit_cnt_d;
    logic                pending;
    logic                pending_d;

    logic                phase_load_c;
    logic [PW-1:0]       phase_val_c;
    logic                phase_expire_c;
    logic                sample_c;
    logic                commit_c;

    logic [NUM_BITS-1:0] shift_1;
    logic [NUM_BITS-1:0] shift_2;
    logic [NUM_BITS-1:0] buttons_1;
    logic [NUM_BITS-1:0] buttons_2;
    logic                ctrl_latch;
    logic                ctrl_clk;
    logic                busy;
    logic                done;

    // Phase duration timer, reloaded on every state entry.
    controller_phase_timer #(
        .WIDTH (PW)
    ) u_phase_timer (
        .clk_1    (clk_1),
        .rst_B    (rst_B),
        .load     (phase_load_c),
        .load_val (phase_val_c),
        .expire_c (phase_expire_c)
    );

    // Next-state, bit counter, pending request and timer reload.
    always_comb begin
        state_d      = state;
        bit_cnt_d    = bit_cnt;
        pending_d    = pending;
        phase_load_c = 1'b0;
        phase_val_c  = '0;

        case (state)
            IDLE: begin
                if (bus.start && bus.enable) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                if (phase_expire_c) begin
                    state_d = LOW;
                end
            end
            LOW: begin
                if (phase_expire_c) begin
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (phase_expire_c) begin
                    bit_cnt_d = bit_cnt + CW'(1);
                    state_d   = (bit_cnt_d == CW'(NUM_BITS)) ? COMMIT : LOW;
                end
            end
            COMMIT: begin
                // A start landing in COMMIT is serviced directly, never parked in IDLE.
                state_d = (bus.enable && (pending || bus.start)) ? LATCH : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // One-deep request memory; dropping enable discards it.
        if (!bus.enable || (state == COMMIT)) begin
            pending_d = 1'b0;
        end else if (bus.start && (state != IDLE)) begin
            pending_d = 1'b1;
        end

        if (state_d != state) begin
            phase_load_c = 1'b1;
            case (state_d)
                LATCH:     phase_val_c = PW'(LATCH_CYCLES - 1);
                LOW, HIGH: phase_val_c = PW'(CLK_DIV - 1);
                default:   phase_val_c = '0;
            endcase
            if (state_d == LATCH) begin
                bit_cnt_d = '0;
            end
        end
    end

    assign sample_c = (state == LOW) && phase_expire_c;
    assign commit_c = (state == COMMIT);

    // State register; pad and status outputs decoded from next state so they are flop-driven.
    always_ff @(posedge clk_1 or negedge rst_B) begin
        if (!rst_B) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            pending    <= 1'b0;
            ctrl_latch <= 1'b0;
            ctrl_clk   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_d;
            bit_cnt    <= bit_cnt_d;
            pending    <= pending_d;
            ctrl_latch <= (state_d == LATCH);
            ctrl_clk   <= (state_d == HIGH);
            busy       <= (state_d != IDLE);
            done       <= commit_c;
        end
    end

    // Shift in inverted serial data at the end of LOW; commit both bytes together.
    always_ff @(posedge clk_1 or negedge rst_B) begin
        if (!rst_B) begin
            shift_1   <= '0;
            shift_2   <= '0;
            buttons_1 <= '0;
            buttons_2 <= '0;
        end else begin
            if (sample_c) begin
                shift_1 <= {shift_1[NUM_BITS-2:0], ~bus.ctrl_1_data_in_B};
                shift_2 <= {shift_2[NUM_BITS-2:0], ~bus.ctrl_2_data_in_B};
            end
            if (commit_c) begin
                buttons_1 <= shift_1;
                buttons_2 <= shift_2;
            end
        end
    end

    assign bus.ctrl_latch = ctrl_latch;
    assign bus.ctrl_clk   = ctrl_clk;
    assign bus.buttons_1  = buttons_1;
    assign bus.buttons_2  = buttons_2;
    assign bus.busy       = busy;
    assign bus.done       = done;

endmodule
